// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the RISC controller: FSM states, instruction
// fields, datapath select codes and the packed control-word layout.
package cpu_ctrl_pkg;

  typedef enum logic [4:0] {
    RST   = 5'd0,
    IF1   = 5'd1,
    IF2   = 5'd2,
    UPC   = 5'd3,
    DEC   = 5'd4,
    WIMM  = 5'd5,
    GETA  = 5'd6,
    GETB  = 5'd7,
    ALU   = 5'd8,
    WRD   = 5'd9,
    CMPS  = 5'd10,
    ADDR  = 5'd11,
    LADDR = 5'd12,
    MRD   = 5'd13,
    WBM   = 5'd14,
    GETD  = 5'd15,
    STC   = 5'd16,
    MWR   = 5'd17,
    HALT  = 5'd18
  } state_t;

  // opcode field (IR[15:13])
  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_HALT = 3'b111;

  // op field (IR[12:11])
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;
  localparam logic [1:0] OP_MEM     = 2'b00;

  // memory command
  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  // register-file select
  localparam logic [1:0] NSEL_RN = 2'b00;
  localparam logic [1:0] NSEL_RD = 2'b01;
  localparam logic [1:0] NSEL_RM = 2'b10;

  // writeback source select
  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_IMM   = 2'b01;
  localparam logic [1:0] VSEL_MDATA = 2'b10;

  typedef struct packed {
    logic       load_ir;
    logic       load_pc;
    logic       reset_pc;
    logic       addr_sel;
    logic       load_addr;
    logic [1:0] mem_cmd;
    logic [1:0] nsel;
    logic [1:0] vsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic       write;
    logic       halted;
    logic       illegal;
  } ctrl_t;

  // Moore control word for a state; mov_reg selects the zero-A ALU pass,
  // ill_flag is the latched undefined-instruction cause shown in HALT.
  function automatic ctrl_t state_outputs(state_t s, logic mov_reg, logic ill_flag);
    ctrl_t c;
    c         = '0;
    c.mem_cmd = MEM_NONE;
    c.nsel    = NSEL_RN;
    c.vsel    = VSEL_C;
    case (s)
      RST: begin
        c.reset_pc = 1'b1;
        c.load_pc  = 1'b1;
      end
      IF1: begin
        c.addr_sel = 1'b1;
        c.mem_cmd  = MEM_READ;
      end
      IF2: begin
        c.addr_sel = 1'b1;
        c.mem_cmd  = MEM_READ;
        c.load_ir  = 1'b1;
      end
      UPC: c.load_pc = 1'b1;
      WIMM: begin
        c.nsel  = NSEL_RN;
        c.vsel  = VSEL_IMM;
        c.write = 1'b1;
      end
      GETA: begin
        c.nsel  = NSEL_RN;
        c.loada = 1'b1;
      end
      GETB: begin
        c.nsel  = NSEL_RM;
        c.loadb = 1'b1;
      end
      ALU: begin
        c.loadc = 1'b1;
        c.asel  = mov_reg;
      end
      WRD: begin
        c.nsel  = NSEL_RD;
        c.vsel  = VSEL_C;
        c.write = 1'b1;
      end
      CMPS: c.loads = 1'b1;
      ADDR: begin
        c.bsel  = 1'b1;
        c.loadc = 1'b1;
      end
      LADDR: c.load_addr = 1'b1;
      MRD: begin
        c.addr_sel = 1'b0;
        c.mem_cmd  = MEM_READ;
      end
      WBM: begin
        c.addr_sel = 1'b0;
        c.mem_cmd  = MEM_READ;
        c.nsel     = NSEL_RD;
        c.vsel     = VSEL_MDATA;
        c.write    = 1'b1;
      end
      GETD: begin
        c.nsel  = NSEL_RD;
        c.loadb = 1'b1;
      end
      STC: begin
        c.asel  = 1'b1;
        c.bsel  = 1'b0;
        c.loadc = 1'b1;
      end
      MWR: begin
        c.addr_sel = 1'b0;
        c.mem_cmd  = MEM_WRITE;
      end
      HALT: begin
        c.halted  = 1'b1;
        c.illegal = ill_flag;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cpu_controller.sv
// Moore sequencer for the simple RISC datapath: fetch, PC update, decode
// and multi-cycle execute. Outputs are registered alongside the state so
// they always reflect the current state without combinational glitches.
module cpu_controller
  import cpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       load_ir,
  output logic       load_pc,
  output logic       reset_pc,
  output logic       addr_sel,
  output logic       load_addr,
  output logic [1:0] mem_cmd,
  output logic [1:0] nsel,
  output logic [1:0] vsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic       write,
  output logic       halted,
  output logic       illegal
);

  state_t state;
  state_t next_state;
  logic   illegal_q;
  logic   next_illegal;
  logic   mov_reg;
  ctrl_t  ctrl;

  assign mov_reg = (opcode == OPC_MOV) && (op == OP_MOV_REG);

  // Next-state and illegal-cause selection from current state and live IR fields
  always_comb begin
    next_state   = RST;
    next_illegal = illegal_q;
    case (state)
      RST: next_state = IF1;
      IF1: next_state = IF2;
      IF2: next_state = UPC;
      UPC: next_state = DEC;
      DEC: begin
        next_illegal = 1'b0;
        casez ({opcode, op})
          {OPC_MOV, OP_MOV_IMM}: next_state = WIMM;
          {OPC_MOV, OP_MOV_REG}: next_state = GETB;
          {OPC_ALU, OP_ADD}:     next_state = GETA;
          {OPC_ALU, OP_CMP}:     next_state = GETA;
          {OPC_ALU, OP_AND}:     next_state = GETA;
          {OPC_ALU, OP_MVN}:     next_state = GETB;
          {OPC_LDR, OP_MEM}:     next_state = GETA;
          {OPC_STR, OP_MEM}:     next_state = GETA;
          {OPC_HALT, 2'b??}:     next_state = HALT;
          default: begin
            next_state   = HALT;
            next_illegal = 1'b1;
          end
        endcase
      end
      WIMM: next_state = IF1;
      GETA: next_state = ((opcode == OPC_LDR) || (opcode == OPC_STR)) ? ADDR : GETB;
      GETB: next_state = ((opcode == OPC_ALU) && (op == OP_CMP)) ? CMPS : ALU;
      ALU:   next_state = WRD;
      WRD:   next_state = IF1;
      CMPS:  next_state = IF1;
      ADDR:  next_state = LADDR;
      LADDR: next_state = (opcode == OPC_LDR) ? MRD : GETD;
      MRD:   next_state = WBM;
      WBM:   next_state = IF1;
      GETD:  next_state = STC;
      STC:   next_state = MWR;
      MWR:   next_state = IF1;
      HALT:  next_state = HALT;
      default: next_state = RST;
    endcase
  end

  // State, illegal cause and control word registered together; the control
  // word is decoded from next_state so it lines up with the state it describes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RST;
      illegal_q <= 1'b0;
      ctrl      <= state_outputs(RST, 1'b0, 1'b0);
    end else begin
      state     <= next_state;
      illegal_q <= next_illegal;
      ctrl      <= state_outputs(next_state, mov_reg, next_illegal);
    end
  end

  // Port fan-out of the registered control word
  always_comb begin
    load_ir   = ctrl.load_ir;
    load_pc   = ctrl.load_pc;
    reset_pc  = ctrl.reset_pc;
    addr_sel  = ctrl.addr_sel;
    load_addr = ctrl.load_addr;
    mem_cmd   = ctrl.mem_cmd;
    nsel      = ctrl.nsel;
    vsel      = ctrl.vsel;
    loada     = ctrl.loada;
    loadb     = ctrl.loadb;
    loadc     = ctrl.loadc;
    loads     = ctrl.loads;
    asel      = ctrl.asel;
    bsel      = ctrl.bsel;
    write     = ctrl.write;
    halted    = ctrl.halted;
    illegal   = ctrl.illegal;
  end

endmodule
